// File: rtl/alu_op_sequencer.sv
// Purpose  : micro-step controller driving data_path strobes for one register-register ALU op.
// Latency  : done pulses EXEC_CYCLES+3 (narrow) or EXEC_CYCLES+4 (wide, HI/LO) cycles after acceptance.
// Backpres.: start is sampled only in IDLE/FINISH; a start while busy is dropped, never queued.
//
// Ports:
//   Clock, clear          : clock and synchronous active-high reset
//   start, op_in, rs/rt/rd : request strobe, opcode and register numbers
//   busy, done             : in-progress flag and one-cycle completion pulse
//   op, Rout, Rin          : ALU opcode and one-hot register bus-out / write enables
//   Yin .. LOin            : data_path strobes of the same names
// All outputs are registered; each is decoded from the next-state values so that the
// strobes for a cycle are valid from the rising edge that begins it.
module alu_op_sequencer #(
   parameter int         EXEC_CYCLES = 1,
   parameter logic [4:0] OP_MUL      = 5'b01010,
   parameter logic [4:0] OP_DIV      = 5'b01011
) (
   input  logic        Clock,
   input  logic        clear,
   input  logic        start,
   input  logic [4:0]  op_in,
   input  logic [3:0]  rs,
   input  logic [3:0]  rt,
   input  logic [3:0]  rd,
   output logic        busy,
   output logic        done,
   output logic [4:0]  op,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        Yin,
   output logic        ZHighin,
   output logic        Zlowin,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        HIin,
   output logic        LOin
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_Y,
      S_EXEC,
      S_WRITE_RD,
      S_WRITE_LO,
      S_WRITE_HI,
      S_FINISH
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;

   // latched request
   logic [4:0] op_q, op_nxt;
   logic [3:0] rs_q, rs_nxt;
   logic [3:0] rt_q, rt_nxt;
   logic [3:0] rd_q, rd_nxt;
   logic       wide_q, wide_nxt;

   // output values for the cycle that starts at the next edge
   logic        busy_nxt, done_nxt;
   logic [4:0]  op_out_nxt;
   logic [15:0] rout_nxt, rin_nxt;
   logic        yin_nxt, zhighin_nxt, zlowin_nxt;
   logic        zhighout_nxt, zlowout_nxt, hiin_nxt, loin_nxt;

   // next-state and request latch
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      op_nxt    = op_q;
      rs_nxt    = rs_q;
      rt_nxt    = rt_q;
      rd_nxt    = rd_q;
      wide_nxt  = wide_q;
      case (state)
         S_IDLE, S_FINISH: begin
            // FINISH accepts a new request exactly like IDLE (back-to-back issue)
            if (start) begin
               state_nxt = S_LOAD_Y;
               op_nxt    = op_in;
               rs_nxt    = rs;
               rt_nxt    = rt;
               rd_nxt    = rd;
               wide_nxt  = (op_in == OP_MUL) || (op_in == OP_DIV);
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_LOAD_Y: begin
            state_nxt = S_EXEC;
            cnt_nxt   = CNT_INIT;
         end
         S_EXEC: begin
            if (cnt == 4'd0) begin
               state_nxt = wide_q ? S_WRITE_LO : S_WRITE_RD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_WRITE_RD: state_nxt = S_FINISH;
         S_WRITE_LO: state_nxt = S_WRITE_HI;
         S_WRITE_HI: state_nxt = S_FINISH;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Moore decode of the next state; registered below so outputs never see inputs directly
   always_comb begin
      busy_nxt     = 1'b0;
      done_nxt     = 1'b0;
      op_out_nxt   = 5'd0;
      rout_nxt     = 16'd0;
      rin_nxt      = 16'd0;
      yin_nxt      = 1'b0;
      zhighin_nxt  = 1'b0;
      zlowin_nxt   = 1'b0;
      zhighout_nxt = 1'b0;
      zlowout_nxt  = 1'b0;
      hiin_nxt     = 1'b0;
      loin_nxt     = 1'b0;
      case (state_nxt)
         S_LOAD_Y: begin
            busy_nxt = 1'b1;
            rout_nxt = 16'b1 << rs_nxt;
            yin_nxt  = 1'b1;
         end
         S_EXEC: begin
            busy_nxt   = 1'b1;
            rout_nxt   = 16'b1 << rt_nxt;
            op_out_nxt = op_nxt;
            // Z is captured only in the last execute cycle, once a multi-cycle result has settled
            zhighin_nxt = (cnt_nxt == 4'd0);
            zlowin_nxt  = (cnt_nxt == 4'd0);
         end
         S_WRITE_RD: begin
            busy_nxt    = 1'b1;
            zlowout_nxt = 1'b1;
            rin_nxt     = 16'b1 << rd_nxt;
         end
         S_WRITE_LO: begin
            busy_nxt    = 1'b1;
            zlowout_nxt = 1'b1;
            loin_nxt    = 1'b1;
         end
         S_WRITE_HI: begin
            busy_nxt     = 1'b1;
            zhighout_nxt = 1'b1;
            hiin_nxt     = 1'b1;
         end
         S_FINISH: done_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (clear) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         op_q     <= 5'd0;
         rs_q     <= 4'd0;
         rt_q     <= 4'd0;
         rd_q     <= 4'd0;
         wide_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         op       <= 5'd0;
         Rout     <= 16'd0;
         Rin      <= 16'd0;
         Yin      <= 1'b0;
         ZHighin  <= 1'b0;
         Zlowin   <= 1'b0;
         Zhighout <= 1'b0;
         Zlowout  <= 1'b0;
         HIin     <= 1'b0;
         LOin     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         op_q     <= op_nxt;
         rs_q     <= rs_nxt;
         rt_q     <= rt_nxt;
         rd_q     <= rd_nxt;
         wide_q   <= wide_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         op       <= op_out_nxt;
         Rout     <= rout_nxt;
         Rin      <= rin_nxt;
         Yin      <= yin_nxt;
         ZHighin  <= zhighin_nxt;
         Zlowin   <= zlowin_nxt;
         Zhighout <= zhighout_nxt;
         Zlowout  <= zlowout_nxt;
         HIin     <= hiin_nxt;
         LOin     <= loin_nxt;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (EXEC_CYCLES=1 and 4) share one stimulus.
// Each instance has a small data_path model (register file, Y, Z, HI, LO) driven by its strobes,
// and a per-cycle expected-output trace built from the request timing table.
module tb_alu_op_sequencer;

   localparam logic [4:0] MUL = 5'b01010;
   localparam logic [4:0] DIV = 5'b01011;
   localparam logic [4:0] ADD = 5'b00011;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       start = 1'b0;
   logic [4:0] op_in = 5'd0;
   logic [3:0] rs = 4'd0, rt = 4'd0, rd = 4'd0;

   logic        busy_w[2], done_w[2], yin_w[2], zhi_w[2], zli_w[2];
   logic        zho_w[2], zlo_w[2], hiin_w[2], loin_w[2];
   logic [4:0]  op_w[2];
   logic [15:0] rout_w[2], rin_w[2];
   logic [45:0] obs[2];

   always #5 clk = ~clk;

   alu_op_sequencer #(.EXEC_CYCLES(1)) dut1 (
      .Clock(clk), .clear(clear), .start(start), .op_in(op_in), .rs(rs), .rt(rt), .rd(rd),
      .busy(busy_w[0]), .done(done_w[0]), .op(op_w[0]), .Rout(rout_w[0]), .Rin(rin_w[0]),
      .Yin(yin_w[0]), .ZHighin(zhi_w[0]), .Zlowin(zli_w[0]), .Zhighout(zho_w[0]),
      .Zlowout(zlo_w[0]), .HIin(hiin_w[0]), .LOin(loin_w[0]));

   alu_op_sequencer #(.EXEC_CYCLES(4)) dut4 (
      .Clock(clk), .clear(clear), .start(start), .op_in(op_in), .rs(rs), .rt(rt), .rd(rd),
      .busy(busy_w[1]), .done(done_w[1]), .op(op_w[1]), .Rout(rout_w[1]), .Rin(rin_w[1]),
      .Yin(yin_w[1]), .ZHighin(zhi_w[1]), .Zlowin(zli_w[1]), .Zhighout(zho_w[1]),
      .Zlowout(zlo_w[1]), .HIin(hiin_w[1]), .LOin(loin_w[1]));

   always_comb begin
      for (int i = 0; i < 2; i++)
         obs[i] = {busy_w[i], done_w[i], op_w[i], rout_w[i], rin_w[i],
                   yin_w[i], zhi_w[i], zli_w[i], zho_w[i], zlo_w[i], hiin_w[i], loin_w[i]};
   end

   // ---------------- data_path model ----------------
   logic [31:0] rf[2][16];
   logic [31:0] y[2], hi[2], lo[2];
   logic [63:0] z[2];
   logic        pl_vld = 1'b0;
   logic [3:0]  pl_r = 4'd0;
   logic [31:0] pl_v = 32'd0;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [31:0] bus;
         bus = 32'd0;
         for (int r = 0; r < 16; r++) if (rout_w[i][r]) bus = bus | rf[i][r];
         if (zlo_w[i]) bus = bus | z[i][31:0];
         if (zho_w[i]) bus = bus | z[i][63:32];
         if (yin_w[i]) y[i] <= bus;
         if (zli_w[i]) begin
            case (op_w[i])
               MUL:     z[i] <= $signed({{32{y[i][31]}}, y[i]}) * $signed({{32{bus[31]}}, bus});
               DIV:     z[i] <= (bus != 0) ? {y[i] % bus, y[i] / bus} : 64'd0;
               ADD:     z[i] <= {32'd0, y[i] + bus};
               default: z[i] <= {32'd0, y[i] ^ bus};
            endcase
         end
         for (int r = 0; r < 16; r++) if (rin_w[i][r]) rf[i][r] <= bus;
         if (hiin_w[i]) hi[i] <= bus;
         if (loin_w[i]) lo[i] <= bus;
         if (pl_vld) rf[i][pl_r] <= pl_v;
      end
   end

   // ---------------- reference trace model ----------------
   int          total = 0, bad = 0, edge_n = 0;
   logic [45:0] q0[$], q1[$];
   logic [45:0] cur_exp[2];
   int          acc_edge[2], acc_cnt[2], done_cnt[2], last_lat[2];
   bit          rout1_seen[2], hilo_seen[2];

   function automatic logic [45:0] vec(input logic b, input logic d, input logic [4:0] o,
                                       input logic [15:0] ro, input logic [15:0] ri,
                                       input logic [6:0] st);
      return {b, d, o, ro, ri, st};
   endfunction

   function automatic logic [15:0] oh(input logic [3:0] n);
      logic [15:0] v;
      v = 16'd0;
      v[n] = 1'b1;
      return v;
   endfunction

   // strobe field order: {Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin}
   task automatic accept(input int i);
      logic [45:0] t[$];
      int  ec;
      bit  wide;
      ec   = (i == 0) ? 1 : 4;
      wide = (op_in == MUL) || (op_in == DIV);
      t.push_back(vec(1'b1, 1'b0, 5'd0, oh(rs), 16'd0, 7'b1000000));
      for (int n = 1; n <= ec; n++)
         t.push_back(vec(1'b1, 1'b0, op_in, oh(rt), 16'd0, (n == ec) ? 7'b0110000 : 7'b0000000));
      if (wide) begin
         t.push_back(vec(1'b1, 1'b0, 5'd0, 16'd0, 16'd0, 7'b0000101));
         t.push_back(vec(1'b1, 1'b0, 5'd0, 16'd0, 16'd0, 7'b0001010));
      end else begin
         t.push_back(vec(1'b1, 1'b0, 5'd0, 16'd0, oh(rd), 7'b0000100));
      end
      t.push_back(vec(1'b0, 1'b1, 5'd0, 16'd0, 16'd0, 7'b0000000));
      foreach (t[k]) if (i == 0) q0.push_back(t[k]); else q1.push_back(t[k]);
      acc_edge[i] = edge_n;
      acc_cnt[i]++;
   endtask

   // one clock: drive inputs, advance the model at the edge, compare after the edge
   task automatic step(input logic s, input logic c);
      start = s;
      clear = c;
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 2; i++) begin
         if (c) begin
            if (i == 0) q0.delete(); else q1.delete();
            cur_exp[i] = 46'd0;
         end else begin
            if (s && !cur_exp[i][45]) accept(i);
            if (i == 0) cur_exp[i] = (q0.size() > 0) ? q0.pop_front() : 46'd0;
            else        cur_exp[i] = (q1.size() > 0) ? q1.pop_front() : 46'd0;
         end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs[i] !== cur_exp[i]) begin
            bad++;
            $display("FAIL trace inst%0d edge%0d got=%h want=%h", i, edge_n, obs[i], cur_exp[i]);
         end
         if (done_w[i] === 1'b1) begin
            done_cnt[i]++;
            last_lat[i] = edge_n - acc_edge[i] + 1;
         end
         if (rout_w[i][1] === 1'b1) rout1_seen[i] = 1'b1;
         if (hiin_w[i] === 1'b1 || loin_w[i] === 1'b1) hilo_seen[i] = 1'b1;
      end
   endtask

   task automatic drain(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   task automatic preload(input logic [3:0] r, input logic [31:0] v);
      pl_r   = r;
      pl_v   = v;
      pl_vld = 1'b1;
      @(posedge clk);
      #1 pl_vld = 1'b0;
   endtask

   task automatic set_req(input logic [4:0] o, input logic [3:0] a, b, d);
      op_in = o; rs = a; rt = b; rd = d;
   endtask

   task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s inst%0d got=%h want=%h", name, i, got, want);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);   // clear wins over start
      for (int i = 0; i < 2; i++) chk("reset_outputs", i, 32'(obs[i] != 46'd0), 32'd0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 2; i++) chk("reset_idle", i, 32'(busy_w[i]), 32'd0);
   endtask

   task automatic test_wide_mul();
      preload(4'd3, 32'd12);
      preload(4'd2, 32'hFFFFFFFB);
      preload(4'd7, 32'h0000AAAA);
      set_req(MUL, 4'd3, 4'd2, 4'd7);
      step(1'b1, 1'b0);
      drain(12);
      for (int i = 0; i < 2; i++) begin
         chk("mul_lo", i, lo[i], 32'hFFFFFFC4);
         chk("mul_hi", i, hi[i], 32'hFFFFFFFF);
         chk("mul_rd_untouched", i, rf[i][7], 32'h0000AAAA);
         chk("mul_rs_untouched", i, rf[i][3], 32'd12);
         chk("mul_rt_untouched", i, rf[i][2], 32'hFFFFFFFB);
      end
      chk("mul_latency", 0, 32'(last_lat[0]), 32'd5);
      chk("mul_latency", 1, 32'(last_lat[1]), 32'd8);
   endtask

   task automatic test_narrow();
      preload(4'd4, 32'd7);
      preload(4'd5, 32'd9);
      preload(4'd6, 32'd0);
      hilo_seen[0] = 1'b0; hilo_seen[1] = 1'b0;
      set_req(ADD, 4'd4, 4'd5, 4'd6);
      step(1'b1, 1'b0);
      drain(12);
      for (int i = 0; i < 2; i++) begin
         chk("add_rd", i, rf[i][6], 32'd16);
         chk("add_no_hilo", i, 32'(hilo_seen[i]), 32'd0);
      end
      chk("add_latency", 0, 32'(last_lat[0]), 32'd4);
      chk("add_latency", 1, 32'(last_lat[1]), 32'd7);
   endtask

   task automatic test_busy();
      int d0[2];
      preload(4'd1, 32'h00001111);
      rout1_seen[0] = 1'b0; rout1_seen[1] = 1'b0;
      d0[0] = done_cnt[0]; d0[1] = done_cnt[1];
      set_req(MUL, 4'd3, 4'd2, 4'd9);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      set_req(ADD, 4'd1, 4'd1, 4'd1);   // arrives during EXEC in both instances
      step(1'b1, 1'b0);
      drain(12);
      for (int i = 0; i < 2; i++) begin
         chk("busy_no_rout1", i, 32'(rout1_seen[i]), 32'd0);
         chk("busy_lo", i, lo[i], 32'hFFFFFFC4);
         chk("busy_r1_intact", i, rf[i][1], 32'h00001111);
         chk("busy_one_done", i, 32'(done_cnt[i] - d0[i]), 32'd1);
      end
   endtask

   task automatic test_back_to_back();
      int d0[2];
      preload(4'd8, 32'd0);
      d0[0] = done_cnt[0]; d0[1] = done_cnt[1];
      set_req(ADD, 4'd4, 4'd5, 4'd8);
      repeat (10) step(1'b1, 1'b0);
      drain(12);
      // held start re-issues at every FINISH: accepts at edges 1, 1+L, 1+2L within 10 edges
      chk("b2b_dones", 0, 32'(done_cnt[0] - d0[0]), 32'd3);
      chk("b2b_dones", 1, 32'(done_cnt[1] - d0[1]), 32'd2);
      for (int i = 0; i < 2; i++) chk("b2b_rd", i, rf[i][8], 32'd16);
   endtask

   task automatic test_clear_mid();
      int d0[2];
      preload(4'd3, 32'd3);
      preload(4'd2, 32'd5);
      d0[0] = done_cnt[0]; d0[1] = done_cnt[1];
      set_req(MUL, 4'd3, 4'd2, 4'd0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("clr_in_write_lo", 0, 32'(loin_w[0]), 32'd1);
      step(1'b0, 1'b1);
      for (int i = 0; i < 2; i++) chk("clr_outputs", i, 32'(obs[i] != 46'd0), 32'd0);
      drain(10);
      for (int i = 0; i < 2; i++) chk("clr_no_done", i, 32'(done_cnt[i] - d0[i]), 32'd0);
      chk("clr_hi_kept", 0, hi[0], 32'hFFFFFFFF);
      step(1'b1, 1'b0);
      drain(12);
      for (int i = 0; i < 2; i++) begin
         chk("clr_restart_done", i, 32'(done_cnt[i] - d0[i]), 32'd1);
         chk("clr_restart_lo", i, lo[i], 32'd15);
         chk("clr_restart_hi", i, hi[i], 32'd0);
      end
   endtask

   task automatic test_random();
      logic [4:0] o;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0:       o = MUL;
            1:       o = DIV;
            default: o = 5'($urandom_range(0, 31));
         endcase
         set_req(o, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         step($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      end
      drain(12);
      for (int i = 0; i < 2; i++) chk("rand_idle", i, 32'(busy_w[i]), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         cur_exp[i] = 46'd0; acc_edge[i] = 0; acc_cnt[i] = 0;
         done_cnt[i] = 0; last_lat[i] = 0; rout1_seen[i] = 1'b0; hilo_seen[i] = 1'b0;
      end
      #1;
      test_reset();
      test_wide_mul();
      test_narrow();
      test_busy();
      test_back_to_back();
      test_clear_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Micro-step controller that drives the `data_path` control strobes to execute one register-register ALU operation.
- Latches a request (opcode, source registers, destination register) and sequences bus-out/bus-in strobes through Y, Z, HI/LO and the register file.
- Signals completion with a one-cycle `done` pulse.
- Sits between the future instruction decoder and `data_path`, replacing hand-driven strobe sequences.

## Interface
Parameters:
- EXEC_CYCLES, 1: cycles the ALU operands and `op` are held before Z is captured. Legal range 1..15. Covers multi-cycle multiply/divide.
- OP_MUL, 5'b01010: opcode whose 64-bit result goes to HI/LO.
- OP_DIV, 5'b01011: opcode whose 64-bit result goes to HI/LO.

Ports:
- Clock  in  1  system clock, all state changes on rising edge
- clear  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only when idle
- op_in  in  5  ALU opcode for the request
- rs  in  4  first source register; its value is loaded into Y
- rt  in  4  second source register; driven on the bus during execute
- rd  in  4  destination register; ignored for OP_MUL/OP_DIV
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle completion pulse
- op  out  5  opcode to `data_path` ALU
- Rout  out  16  one-hot register bus-out enables (bit n = Rn out)
- Rin  out  16  one-hot register write enables (bit n = Rn in)
- Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin  out  1 each  `data_path` strobes of the same names

## Operation
- Outputs are registered (Moore): they are decoded from the state register, the execute counter and the latched request. There is no combinational path from any input to any output.
- Request latch: on a rising edge in IDLE with `start`=1, latch `op_in`, `rs`, `rt`, `rd`, and classify the request:
  - wide = (`op_in`==OP_MUL || `op_in`==OP_DIV).
  - narrow = any other 5-bit opcode. No opcode is rejected.
- States and outputs (every output not listed is 0):
  - IDLE: `busy`=0.
    - `start`=1 → LOAD_Y.
  - LOAD_Y: `Rout[rs]`=1, `Yin`=1.
    - Always → EXEC; execute counter set to EXEC_CYCLES-1.
  - EXEC: `Rout[rt]`=1, `op`=latched op.
    - When counter==0: `ZHighin`=1 and `Zlowin`=1.
    - Counter decrements each cycle. When it is 0 → WRITE_LO if wide, WRITE_RD if narrow.
  - WRITE_RD: `Zlowout`=1, `Rin[rd]`=1.
    - Always → FINISH.
  - WRITE_LO: `Zlowout`=1, `LOin`=1.
    - Always → WRITE_HI.
  - WRITE_HI: `Zhighout`=1, `HIin`=1.
    - Always → FINISH.
  - FINISH: `done`=1, `busy`=0. Behaves as IDLE for `start`:
    - `start`=1 → LOAD_Y (back-to-back).
    - Otherwise → IDLE.
- `busy`=1 in LOAD_Y, EXEC, WRITE_*.
- `op` is 0 outside EXEC.
- Boundary rules:
  - `start` while `busy`: ignored. No queuing, latched request unchanged.
  - `rs`==`rt`: legal. Same register is read twice.
  - `rd`==`rs` or `rd`==`rt`: legal. Write occurs after both reads.
  - EXEC_CYCLES==1: EXEC lasts exactly one cycle with ZHighin/Zlowin asserted in it.
  - At most one bit of `Rout` is set in any cycle; same for `Rin`. Exactly one bus-out source is active per non-idle cycle.
  - `clear`=1 at any edge: next state IDLE. All outputs 0, counter 0, latched request 0. No `done` is issued for the aborted request. `clear` has priority over `start` on the same edge.

## Timing
- Reset values: busy=0, done=0, op=0, Rout=0, Rin=0, all strobes 0.
- Request accepted at edge k (cycle numbers are cycles after that edge):
  - LOAD_Y: cycle k+1.
  - EXEC: cycles k+2 .. k+1+E (E = EXEC_CYCLES).
  - Z captured at the end of cycle k+1+E.
- Narrow: WRITE_RD at k+2+E; `done` at k+3+E. Latency E+3.
- Wide: WRITE_LO at k+2+E; WRITE_HI at k+3+E; `done` at k+4+E. Latency E+4.
- Strobes are stable for the whole cycle. `data_path` samples them on the following rising edge.
- Maximum throughput: one request every E+3 (narrow) or E+4 (wide) cycles when `start` is held high.

## Test plan
- Wide multiply, E=1: R3=12, R2=-5 (32'hFFFFFFFB); start op_in=5'b01010, rs=3, rt=2 → LO=32'hFFFFFFC4, HI=32'hFFFFFFFF; `done` exactly 5 cycles after acceptance; R0..R15 unchanged.
- Narrow op, E=1: R4=7, R5=9; start an add opcode with rs=4, rt=5, rd=6 → R6=16 at WRITE_RD; HIin/LOin never asserted; `done` 4 cycles after acceptance.
- Multi-cycle, E=4: same multiply as first scenario → ZHighin/Zlowin asserted only in the 4th EXEC cycle; Rout[2] and op=5'b01010 held all 4 EXEC cycles; `done` 8 cycles after acceptance.
- Busy protection: second start (rs=1) pulsed in EXEC → ignored; first result intact; `Rout[1]` never asserted.
- Back-to-back: `start` held high → second LOAD_Y in the cycle after FINISH; `done` pulses once per request.
- Reset mid-op: `clear`=1 during WRITE_LO → next cycle all outputs 0, HI unchanged, no `done`; a new start afterwards completes normally.
